// File: rtl/slice_concat_packer_pkg.sv
// Shared derivations and parameter legality checks for the slice/concat packer.
package slice_concat_packer_pkg;

  // Width of one extracted field.
  function automatic int field_width(input int hi, input int lo);
    return hi - lo;
  endfunction

  // Width of a packed output word.
  function automatic int out_width(input int num, input int hi, input int lo);
    return num * (hi - lo);
  endfunction

  // Width needed to hold a field count of 0..num.
  function automatic int count_width(input int num);
    return $clog2(num + 1);
  endfunction

  // True when the parameter set describes a buildable packer.
  function automatic bit params_legal(input int width, input int hi, input int lo, input int num);
    return (width >= hi) && (hi > lo) && (lo >= 0) && (num >= 2);
  endfunction

endpackage

// File: rtl/coreir_slice.sv
// Field extractor: returns in[HI-1:LO] as a right-aligned field.
module coreir_slice
  import slice_concat_packer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HI    = 15,
  parameter int LO    = 3,
  localparam int FW   = field_width(HI, LO)
) (
  input  logic [WIDTH-1:0] in,
  output logic [FW-1:0]    out
);

  // Mask of the input bits that lie outside the extracted field.
  function automatic logic [WIDTH-1:0] outside_mask();
    logic [WIDTH-1:0] m;
    m = {WIDTH{1'b1}};
    for (int i = LO; i < HI; i++) begin
      m[i] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [WIDTH-1:0] OUTSIDE = outside_mask();

  // Bits outside the field are intentionally discarded.
  logic unused_bits;
  assign unused_bits = ^(in & OUTSIDE);

  assign out = in[HI-1:LO];

endmodule

// File: rtl/slice_concat_packer.sv
// Packs the in[HI-1:LO] field of successive input words into NUM-field output
// words, first field least significant, with a flush to emit partial words.
module slice_concat_packer
  import slice_concat_packer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int HI    = 15,
  parameter int LO    = 3,
  parameter int NUM   = 4,
  localparam int FW   = field_width(HI, LO),
  localparam int OW   = out_width(NUM, HI, LO),
  localparam int CW   = count_width(NUM)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OW-1:0]    out,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  if (!params_legal(WIDTH, HI, LO, NUM)) begin : g_param_check
    $error("slice_concat_packer: illegal WIDTH/HI/LO/NUM combination");
  end

  logic [FW-1:0] field;
  logic [OW-1:0] acc_r;
  logic [CW-1:0] cnt_r;
  logic [OW-1:0] merged;
  logic [CW-1:0] count_next;
  logic          slot_free;
  logic          at_last;
  logic          accept;
  logic          flush_act;
  logic          load;

  coreir_slice #(
    .WIDTH (WIDTH),
    .HI    (HI),
    .LO    (LO)
  ) u_slice (
    .in  (in),
    .out (field)
  );

  // Handshake and action decode; in_ready deliberately ignores in_valid.
  assign slot_free = !out_valid || out_ready;
  assign at_last   = (cnt_r == CW'(NUM - 1));
  assign in_ready  = !at_last || slot_free;
  assign accept    = in_valid && in_ready;
  assign flush_act = flush && slot_free && ((cnt_r != {CW{1'b0}}) || accept);
  assign load      = (accept && at_last) || flush_act;

  // Accumulator contents with any field accepted this cycle dropped into slot cnt.
  always_comb begin
    merged = acc_r;
    for (int k = 0; k < NUM; k++) begin
      if (accept && (cnt_r == CW'(k))) begin
        merged[k*FW +: FW] = field;
      end else begin
        merged[k*FW +: FW] = acc_r[k*FW +: FW];
      end
    end
    if (accept) begin
      count_next = cnt_r + CW'(1);
    end else begin
      count_next = cnt_r;
    end
  end

  // Accumulator, fill counter and one-entry output register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      acc_r     <= {OW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      out       <= {OW{1'b0}};
      out_count <= {CW{1'b0}};
      out_valid <= 1'b0;
    end else if (load) begin
      // Upper unused fields of a partial word are already zero in the accumulator.
      out       <= merged;
      out_count <= count_next;
      out_valid <= 1'b1;
      acc_r     <= {OW{1'b0}};
      cnt_r     <= {CW{1'b0}};
    end else begin
      if (accept) begin
        acc_r <= merged;
        cnt_r <= count_next;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_slice_concat_packer.sv
// Self-checking bench for slice_concat_packer (WIDTH=16, HI=15, LO=3, NUM=4).
module tb_slice_concat_packer;

  localparam int WIDTH = 16;
  localparam int HI    = 15;
  localparam int LO    = 3;
  localparam int NUM   = 4;
  localparam int FW    = 12;

  logic        clk;
  logic        arst;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [47:0] out_word;
  logic [2:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: fields waiting to be packed, plus the single output slot.
  logic [11:0] pend[$];
  bit          exp_valid;
  logic [47:0] exp_word;
  int          exp_cnt;

  slice_concat_packer #(
    .WIDTH (WIDTH),
    .HI    (HI),
    .LO    (LO),
    .NUM   (NUM)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .in        (in_word),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out       (out_word),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [47:0] pack_pending();
    logic [47:0] w;
    w = 48'h0;
    for (int k = 0; k < pend.size(); k++) begin
      w = w | ({36'h0, pend[k]} << (FW * k));
    end
    return w;
  endfunction

  function automatic bit model_in_ready();
    return (pend.size() != NUM - 1) || !exp_valid || out_ready;
  endfunction

  task automatic model_reset();
    pend.delete();
    exp_valid = 1'b0;
    exp_word  = 48'h0;
    exp_cnt   = 0;
  endtask

  // Apply one cycle of inputs (called at the falling edge); outputs settle 1 time unit later.
  task automatic drive(input bit iv, input logic [15:0] d, input bit fl, input bit ordy);
    in_valid  = iv;
    in_word   = d;
    flush     = fl;
    out_ready = ordy;
    #1;
  endtask

  // Advance the reference model by one clock using the driven inputs, then clock the DUT.
  task automatic advance();
    bit sf;
    bit acc;
    sf  = !exp_valid || out_ready;
    acc = in_valid && ((pend.size() != NUM - 1) || sf);
    if (exp_valid && out_ready) exp_valid = 1'b0;
    if (acc) pend.push_back(in_word[14:3]);
    if ((pend.size() == NUM) || (flush && sf && (pend.size() > 0))) begin
      exp_word  = pack_pending();
      exp_cnt   = pend.size();
      exp_valid = 1'b1;
      pend.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    arst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_word !== 48'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", out_word); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_full_word();
    logic [15:0] w[4];
    w = '{16'h0008, 16'h0010, 16'h0018, 16'h0020};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], 1'b0, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready[%0d]: got %b expected 1", i, in_ready); end
      advance();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", out_valid); end
    checks++; if (out_word !== 48'h004003002001) begin errors++; $display("FAIL full_out: got %h expected 004003002001", out_word); end
    checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", out_count); end
    drive(1'b0, 16'h0, 1'b0, 1'b1);
    advance();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_one_cycle: got %b expected 0", out_valid); end
  endtask

  task automatic test_flush_partial();
    drive(1'b1, 16'h7FF8, 1'b0, 1'b1); advance();
    drive(1'b1, 16'h0008, 1'b0, 1'b1); advance();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush2_early: got %b expected 0", out_valid); end
    drive(1'b0, 16'h0, 1'b1, 1'b1); advance();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush2_valid: got %b expected 1", out_valid); end
    checks++; if (out_word !== 48'h000000001FFF) begin errors++; $display("FAIL flush2_out: got %h expected 000000001fff", out_word); end
    checks++; if (out_count !== 3'd2) begin errors++; $display("FAIL flush2_count: got %0d expected 2", out_count); end
    drive(1'b0, 16'h0, 1'b0, 1'b1); advance();
  endtask

  task automatic test_flush_concurrent();
    drive(1'b1, 16'h0008, 1'b0, 1'b1); advance();
    drive(1'b1, 16'h0010, 1'b0, 1'b1); advance();
    drive(1'b1, 16'h0018, 1'b1, 1'b1); advance();
    checks++; if (out_word !== 48'h000003002001) begin errors++; $display("FAIL flush3_out: got %h expected 000003002001", out_word); end
    checks++; if (out_count !== 3'd3) begin errors++; $display("FAIL flush3_count: got %0d expected 3", out_count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush3_valid: got %b expected 1", out_valid); end
    drive(1'b0, 16'h0, 1'b0, 1'b1); advance();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 16'((i + 1) << 3), 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 1", i, in_ready); end
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0040, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", i, in_ready); end
      checks++; if ((out_valid !== 1'b1) || (out_word !== 48'h004003002001) || (out_count !== 3'd4))
        begin errors++; $display("FAIL bp_hold[%0d]: got v=%b %h n=%0d expected v=1 004003002001 n=4", i, out_valid, out_word, out_count); end
      advance();
    end
    drive(1'b1, 16'h0040, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    advance();
    checks++; if ((out_valid !== 1'b1) || (out_word !== 48'h008007006005) || (out_count !== 3'd4))
      begin errors++; $display("FAIL bp_second: got v=%b %h n=%0d expected v=1 008007006005 n=4", out_valid, out_word, out_count); end
    drive(1'b0, 16'h0, 1'b0, 1'b1); advance();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 16'((i + 9) << 3), 1'b0, 1'b0);
      advance();
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pending: got %b expected 1", out_valid); end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
    checks++; if ((out_word !== 48'h0) || (out_count !== 3'd0)) begin errors++; $display("FAIL ar_out: got %h n=%0d expected 0 n=0", out_word, out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %b expected 1", in_ready); end
    model_reset();
    @(negedge clk);
    arst = 1'b0;
    drive(1'b1, 16'hABC8, 1'b0, 1'b1); advance();
    drive(1'b1, 16'h0010, 1'b0, 1'b1); advance();
    drive(1'b1, 16'h0018, 1'b0, 1'b1); advance();
    drive(1'b1, 16'h0020, 1'b0, 1'b1); advance();
    checks++; if ((out_valid !== 1'b1) || (out_word[11:0] !== 12'h579))
      begin errors++; $display("FAIL ar_first_field: got v=%b %h expected v=1 579", out_valid, out_word[11:0]); end
    checks++; if (out_word !== 48'h004003002579) begin errors++; $display("FAIL ar_word: got %h expected 004003002579", out_word); end
    drive(1'b0, 16'h0, 1'b0, 1'b1); advance();
  endtask

  task automatic test_flush_empty();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b1);
      advance();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty[%0d]: got %b expected 0", i, out_valid); end
    end
    drive(1'b0, 16'h0, 1'b0, 1'b1); advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
      checks++; if (in_ready !== model_in_ready()) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b expected %b", n, in_ready, model_in_ready()); end
      advance();
      checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if ((out_word !== exp_word) || (out_count !== 3'(exp_cnt)))
          begin errors++; $display("FAIL rnd_word[%0d]: got %h n=%0d expected %h n=%0d", n, out_word, out_count, exp_word, exp_cnt); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_concurrent();
    test_backpressure();
    test_async_reset();
    test_flush_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
